// File: rtl/sync_frame_deser_pkg.sv
// Shared types and default parameters for the serial frame deserializer.
// Imported by the interface, the sync detector and the top level.
package sync_frame_deser_pkg;

  typedef enum logic [1:0] {
    HUNT = 2'd0,
    DATA = 2'd1,
    CHK  = 2'd2
  } deser_state_t;

  localparam int         DEF_DATA_W   = 8;
  localparam int         DEF_WORDS    = 4;
  localparam int         DEF_SYNC_W   = 4;
  localparam logic [3:0] DEF_SYNC_PAT = 4'b1010;
  localparam bit         DEF_CHK_EN   = 1'b1;

  // Word index needs at least one bit even for single-word frames.
  function automatic int idx_width(input int words);
    return (words > 1) ? $clog2(words) : 1;
  endfunction

endpackage

// File: rtl/sync_frame_deser_if.sv
// Bundle of the serial input and parallel word/frame outputs of sync_frame_deser.
// The master side drives the serial bit stream; the slave side is the deserializer.
interface sync_frame_deser_if #(
  parameter int DATA_W = sync_frame_deser_pkg::DEF_DATA_W,
  parameter int WORDS  = sync_frame_deser_pkg::DEF_WORDS
);
  import sync_frame_deser_pkg::*;

  localparam int IDX_W = idx_width(WORDS);

  // Handshake: en is a qualifier, not a request. A bit on data_in is consumed on every
  // rising edge where en=1; there is no ready/backpressure. data_valid and frame_done are
  // single-cycle strobes with no acknowledge, and data_out/word_idx/chk_err hold between them.
  logic              en;
  logic              data_in;
  logic              data_i_o;
  logic [DATA_W-1:0] data_out;
  logic              data_valid;
  logic [IDX_W-1:0]  word_idx;
  logic              frame_done;
  logic              chk_err;
  logic              busy;
  deser_state_t      dbg_state;

  modport master (
    output en, data_in,
    input  data_i_o, data_out, data_valid, word_idx, frame_done, chk_err, busy, dbg_state
  );

  modport slave (
    input  en, data_in,
    output data_i_o, data_out, data_valid, word_idx, frame_done, chk_err, busy, dbg_state
  );

endinterface

// File: rtl/sync_frame_deser_sync_detect.sv
// Serial shift register, hunt-window counter and sync pattern comparator.
// A match needs SYNC_W bits received since entering HUNT, so frame tails never form a sync.
module sync_detect #(
  parameter int                DATA_W   = sync_frame_deser_pkg::DEF_DATA_W,
  parameter int                SYNC_W   = sync_frame_deser_pkg::DEF_SYNC_W,
  parameter logic [SYNC_W-1:0] SYNC_PAT = sync_frame_deser_pkg::DEF_SYNC_PAT
) (
  input  logic              t_clk,
  input  logic              rst_n,
  input  logic              i_en,
  input  logic              i_data,
  input  logic              i_hunt,
  output logic [DATA_W-2:0] o_sr,
  output logic              o_match
);
  import sync_frame_deser_pkg::*;

  localparam int SR_W = DATA_W - 1;
  localparam int HC_W = $clog2(SYNC_W + 1);

  logic [SR_W-1:0]   r_sr;
  logic [HC_W-1:0]   r_hunt_cnt;
  logic [SYNC_W-1:0] w_window;
  logic              w_enough;

  always_ff @(posedge t_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sr       <= '0;
      r_hunt_cnt <= '0;
    end else begin
      if (i_en) begin
        r_sr <= SR_W'({r_sr, i_data});
      end
      if (!i_hunt) begin
        r_hunt_cnt <= '0;
      end else if (i_en && (r_hunt_cnt != HC_W'(SYNC_W))) begin
        r_hunt_cnt <= r_hunt_cnt + HC_W'(1);
      end
    end
  end

  // The window includes the bit being sampled this cycle.
  assign w_window = {r_sr[SYNC_W-2:0], i_data};
  assign w_enough = (r_hunt_cnt >= HC_W'(SYNC_W - 1));
  assign o_match  = i_hunt & i_en & w_enough & (w_window == SYNC_PAT);
  assign o_sr     = r_sr;

endmodule

// File: rtl/sync_frame_deser.sv
// Serial-to-parallel frame deserializer: hunts a sync pattern, then emits WORDS words
// of DATA_W bits (MSB first) and optionally checks a trailing XOR checksum word.
module sync_frame_deser #(
  parameter int                DATA_W   = sync_frame_deser_pkg::DEF_DATA_W,
  parameter int                WORDS    = sync_frame_deser_pkg::DEF_WORDS,
  parameter int                SYNC_W   = sync_frame_deser_pkg::DEF_SYNC_W,
  parameter logic [SYNC_W-1:0] SYNC_PAT = sync_frame_deser_pkg::DEF_SYNC_PAT,
  parameter bit                CHK_EN   = sync_frame_deser_pkg::DEF_CHK_EN
) (
  input  logic                 t_clk,
  input  logic                 rst_n,
  sync_frame_deser_if.slave    bus
);
  import sync_frame_deser_pkg::*;

  localparam int BC_W  = $clog2(DATA_W);
  localparam int WC_W  = $clog2(WORDS + 1);
  localparam int IDX_W = idx_width(WORDS);

  deser_state_t      r_state;
  deser_state_t      w_state_nxt;
  logic [BC_W-1:0]   r_bit_cnt;
  logic [WC_W-1:0]   r_word_cnt;
  logic [DATA_W-1:0] r_acc;
  logic              r_data_i_o;
  logic [DATA_W-1:0] r_data_out;
  logic              r_data_valid;
  logic [IDX_W-1:0]  r_word_idx;
  logic              r_frame_done;
  logic              r_chk_err;
  logic              r_busy;

  logic [DATA_W-2:0] w_sr;
  logic              w_match;
  logic [DATA_W-1:0] w_word;
  logic              w_last_bit;
  logic              w_last_word;
  logic              w_word_done;
  logic              w_chk_done;
  logic              w_frame_end;

  sync_detect #(
    .DATA_W  (DATA_W),
    .SYNC_W  (SYNC_W),
    .SYNC_PAT(SYNC_PAT)
  ) u_sync_detect (
    .t_clk  (t_clk),
    .rst_n  (rst_n),
    .i_en   (bus.en),
    .i_data (bus.data_in),
    .i_hunt (r_state == HUNT),
    .o_sr   (w_sr),
    .o_match(w_match)
  );

  assign w_word      = {w_sr, bus.data_in};
  assign w_last_bit  = (r_bit_cnt == BC_W'(DATA_W - 1));
  assign w_last_word = (r_word_cnt == WC_W'(WORDS - 1));

  always_ff @(posedge t_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= HUNT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_word_done = 1'b0;
    w_chk_done  = 1'b0;
    w_frame_end = 1'b0;
    case (r_state)
      HUNT: begin
        if (w_match) begin
          w_state_nxt = DATA;
        end
      end
      DATA: begin
        if (bus.en && w_last_bit) begin
          w_word_done = 1'b1;
          if (w_last_word) begin
            w_frame_end = !CHK_EN;
            w_state_nxt = CHK_EN ? CHK : HUNT;
          end
        end
      end
      CHK: begin
        if (bus.en && w_last_bit) begin
          w_chk_done  = 1'b1;
          w_frame_end = 1'b1;
          w_state_nxt = HUNT;
        end
      end
      default: w_state_nxt = HUNT;
    endcase
  end

  always_ff @(posedge t_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bit_cnt    <= '0;
      r_word_cnt   <= '0;
      r_acc        <= '0;
      r_data_i_o   <= 1'b0;
      r_data_out   <= '0;
      r_data_valid <= 1'b0;
      r_word_idx   <= '0;
      r_frame_done <= 1'b0;
      r_chk_err    <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_data_i_o   <= bus.data_in;
      r_data_valid <= 1'b0;
      r_frame_done <= w_frame_end;
      r_busy       <= (w_state_nxt != HUNT);

      if (w_match) begin
        r_bit_cnt  <= '0;
        r_word_cnt <= '0;
        r_acc      <= '0;
      end else if (bus.en && (r_state != HUNT)) begin
        r_bit_cnt <= w_last_bit ? '0 : r_bit_cnt + BC_W'(1);
      end

      if (w_word_done) begin
        r_data_out   <= w_word;
        r_data_valid <= 1'b1;
        r_word_idx   <= r_word_cnt[IDX_W-1:0];
        r_acc        <= r_acc ^ w_word;
        r_word_cnt   <= r_word_cnt + WC_W'(1);
      end

      // chk_err only moves at frame end and then holds until the next frame.
      if (w_frame_end) begin
        r_chk_err <= w_chk_done && (w_word != r_acc);
      end
    end
  end

  assign bus.data_i_o   = r_data_i_o;
  assign bus.data_out   = r_data_out;
  assign bus.data_valid = r_data_valid;
  assign bus.word_idx   = r_word_idx;
  assign bus.frame_done = r_frame_done;
  assign bus.chk_err    = r_chk_err;
  assign bus.busy       = r_busy;
  assign bus.dbg_state  = r_state;

endmodule

// File: doc/sync_frame_deser.md
# sync_frame_deser

Parametrised serial-to-parallel deserializer for the self-test data path. It hunts a serial bit stream on `t_clk` for a configurable sync pattern. After a match it captures a fixed-length frame of `WORDS` data words of `DATA_W` bits each, MSB first, and can optionally check a trailing XOR checksum word. Each word is presented with a one-cycle valid strobe and word index, and `data_in` is echoed for loopback to the next die.

## Interface
Parameters:
- `DATA_W`, 8: bits per word, ≥2
- `WORDS`, 4: data words per frame, ≥1
- `SYNC_W`, 4: sync pattern length, 2..DATA_W
- `SYNC_PAT`, 4'b1010: sync pattern; first-received bit is the MSB
- `CHK_EN`, 1: 1 = one XOR checksum word follows the data words

Ports:
- `t_clk`  in  1  clock; all logic on rising edge
- `rst_n`  in  1  reset, asynchronous, active-low
- `en`  in  1  bit-sample enable; when low, no bit is consumed and all state holds
- `data_in`  in  1  serial data, MSB first
- `data_i_o`  out  1  `data_in` registered every cycle, regardless of `en`
- `data_out`  out  DATA_W  last completed data word
- `data_valid`  out  1  one-cycle pulse when `data_out` updates
- `word_idx`  out  $clog2(WORDS) (min 1)  index of the word on `data_out`, 0..WORDS-1
- `frame_done`  out  1  one-cycle pulse at end of frame
- `chk_err`  out  1  valid with `frame_done`; 1 = checksum mismatch; 0 when CHK_EN=0
- `busy`  out  1  1 while state ≠ HUNT

## Operation
- Reset values: all outputs 0, state HUNT, shift register 0, all counters 0, accumulator 0.
- A "sample" is a rising edge with `en`=1. Each sample shifts `data_in` into the LSB of shift register `sr`.
- States:
  - HUNT: `hunt_cnt` counts samples since entering HUNT and saturates at SYNC_W. A match is the last SYNC_W bits, including the current sample, equal to SYNC_PAT. A match is only accepted when `hunt_cnt` ≥ SYNC_W-1, so frame bits never form part of a sync. On a match, go to DATA with `bit_cnt`=0, `word_cnt`=0 and accumulator=0.
  - DATA: on the sample where `bit_cnt`=DATA_W-1, load `data_out` with {sr[DATA_W-2:0], data_in}, pulse `data_valid`, set `word_idx`=`word_cnt`, XOR the word into the accumulator and clear `bit_cnt`. After word WORDS-1, go to CHK if CHK_EN=1, otherwise go to HUNT with `frame_done`=1 and `chk_err`=0.
  - CHK: collect DATA_W bits without touching `data_out` or `data_valid`. On the last bit, set `chk_err` = (received word ≠ accumulator), pulse `frame_done` and go to HUNT.
- `chk_err` holds its value until the next `frame_done`.
- `busy` = (state ≠ HUNT), registered.
- Sync is not searched inside a frame. A sync-like pattern in the data is treated as data.
- `en` low mid-word: counters freeze and the frame resumes on the next sample. No timeout applies.
- Reset mid-frame: immediate return to reset values; the partial frame is discarded.
- Counter widths: `bit_cnt` is $clog2(DATA_W) bits and `word_cnt` is $clog2(WORDS+1) bits. Neither wraps inside a frame.

## Timing
- `data_i_o` lags `data_in` by exactly 1 cycle.
- Sync: with the last pattern bit sampled at edge N, state is DATA and `busy`=1 from edge N. Data bit 0 (MSB) is sampled at edge N+1.
- Word k completes at edge N+DATA_W·(k+1). `data_out`, `data_valid` and `word_idx` are visible in the following cycle. Latency from last bit sampled to output is 1 cycle.
- `frame_done` is asserted in the cycle after edge N+DATA_W·(WORDS+CHK_EN), and `busy` falls on the same edge.
- Back-to-back frames: the earliest next sync completes SYNC_W samples after `frame_done`'s edge.
- `data_valid` and `frame_done` are both asserted in the same cycle only when CHK_EN=0 and the word is the last one.

## Structure
- Package `sync_frame_deser_pkg` holds:
  - the state typedef `deser_state_t` (HUNT, DATA, CHK)
  - default constants DEF_DATA_W, DEF_WORDS, DEF_SYNC_W, DEF_SYNC_PAT
- Sub-module `sync_detect` holds `sr`, `hunt_cnt` and the pattern comparator, and outputs a `match` signal. The top level holds the FSM, the counters, the accumulator and the output registers.

## Test plan
- Defaults: send 1010, then 8'hA5, 8'h3C, 8'h0F, 8'hF0, 8'h66 → four `data_valid` pulses on consecutive word boundaries with `word_idx` 0..3; then `frame_done`=1 and `chk_err`=0 (XOR = 8'h66).
- Same stream with checksum 8'h67 → `chk_err`=1 with `frame_done`; `data_out` holds 8'hF0.
- Noise 0101 1101 before the sync, plus an 8'h0A data word containing 1010 → exactly one frame; no early or extra `data_valid`.
- Toggle `en` low for 3 cycles in mid-word 1 → same words and values, with `frame_done` delayed by exactly 3 cycles; `data_i_o` still follows `data_in` each cycle.
- Assert `rst_n` low after 2 words, then send a full new frame → all outputs 0 during reset; the new frame decodes from `word_idx` 0 and no stale words appear.
- DATA_W=16, WORDS=2, SYNC_W=8, SYNC_PAT=8'hB4, CHK_EN=0 → words 16'h1234 and 16'hABCD arrive; `frame_done` coincides with the second `data_valid` and `chk_err`=0.
